// File: rtl/sign_pkg.sv
// Shared types and constants for the sign-recognition front end.
// palm_bbox_t is the result record handed on to finger identification.
package sign_pkg;

  // BT.601-style luma weights; they sum to 256, so (sum >> 8) never overflows PIX_W.
  localparam int Y_CR = 77;
  localparam int Y_CG = 150;
  localparam int Y_CB = 29;

  // Field width of the bbox record, wide enough for any frame this pipeline targets.
  localparam int BB_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH,
    ST_REPORT
  } fe_state_t;

  typedef struct packed {
    logic            present;
    logic            train;
    logic            err;
    logic [BB_W-1:0] top;
    logic [BB_W-1:0] bottom;
    logic [BB_W-1:0] left;
    logic [BB_W-1:0] right;
    logic [BB_W-1:0] width;
    logic [BB_W-1:0] height;
    logic [BB_W-1:0] count;
  } palm_bbox_t;

endpackage

// File: rtl/sign_bg_ram.sv
// Simple dual-port background store: one write port, one registered read port.
module sign_bg_ram #(
  parameter int DEPTH = 3072,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: memory arrays carry no reset so they map onto block RAM; bg_loaded guards stale contents.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/sign_frame_frontend.sv
// Pixel-stream front end: luma, background learn/subtract, and palm bounding box per frame.
// Two-stage pipeline (S1: luma + RAM read, S2: compare + accumulate), one result per frame.
module sign_frame_frontend
  import sign_pkg::*;
#(
  parameter int PIX_W   = 8,
  parameter int FRAME_W = 64,
  parameter int FRAME_H = 48,
  parameter int DIFF_TH = 24,
  parameter int MIN_PIX = 16,
  localparam int CW = $clog2(FRAME_W),
  localparam int RW = $clog2(FRAME_H),
  localparam int NW = $clog2(FRAME_W*FRAME_H+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             train,
  input  logic             pix_valid,
  output logic             pix_ready,
  input  logic             pix_sof,
  input  logic             pix_eol,
  input  logic [PIX_W-1:0] red,
  input  logic [PIX_W-1:0] green,
  input  logic [PIX_W-1:0] blue,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_present,
  output logic             res_train,
  output logic             res_err,
  output logic [RW-1:0]    res_top,
  output logic [RW-1:0]    res_bottom,
  output logic [CW-1:0]    res_left,
  output logic [CW-1:0]    res_right,
  output logic [CW:0]      res_width,
  output logic [RW:0]      res_height,
  output logic [NW-1:0]    res_count
);

  localparam int DEPTH = FRAME_W * FRAME_H;
  localparam int AW    = $clog2(DEPTH);
  localparam int YW    = PIX_W + 8;
  localparam logic [CW-1:0] LAST_COL = CW'(FRAME_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(FRAME_H - 1);

  fe_state_t state, state_next;

  logic             beat, start, proc, eol_eff, beat_err, frame_end;
  logic [CW-1:0]    col, beat_col;
  logic [RW-1:0]    row, beat_row;
  logic [AW-1:0]    beat_addr;
  logic [YW-1:0]    y_sum;
  logic [PIX_W-1:0] y;

  logic             frame_train, err, bg_loaded;
  logic             s1_valid;
  logic [PIX_W-1:0] s1_y;
  logic [AW-1:0]    s1_addr;
  logic [CW-1:0]    s1_col;
  logic [RW-1:0]    s1_row;
  logic [PIX_W-1:0] bg_y, diff;
  logic             object;

  logic [NW-1:0]    count;
  logic [RW-1:0]    top, bottom;
  logic [CW-1:0]    bb_left, bb_right;
  logic             present;
  palm_bbox_t       res_d, res_q;

  // Pixel beat decode
  assign pix_ready = !rst && (state == ST_IDLE || state == ST_ACTIVE);
  assign res_valid = !rst && (state == ST_REPORT);
  assign beat      = pix_valid && pix_ready;
  assign start     = beat && pix_sof;
  assign proc      = start || (beat && state == ST_ACTIVE);
  assign beat_col  = start ? '0 : col;
  assign beat_row  = start ? '0 : row;
  // A row ends on EOL or on the last column, whichever comes first; disagreement is a framing error.
  assign eol_eff   = pix_eol || (beat_col == LAST_COL);
  assign beat_err  = pix_eol != (beat_col == LAST_COL);
  assign frame_end = proc && eol_eff && (beat_row == LAST_ROW);
  assign beat_addr = AW'(beat_row) * AW'(FRAME_W) + AW'(beat_col);

  assign y_sum = YW'(Y_CR) * YW'(red) + YW'(Y_CG) * YW'(green) + YW'(Y_CB) * YW'(blue);
  assign y     = y_sum[YW-1:8];

  sign_bg_ram #(
    .DEPTH(DEPTH),
    .WIDTH(PIX_W),
    .AW   (AW)
  ) u_bg_ram (
    .clk    (clk),
    .we     (s1_valid && frame_train),
    .wr_addr(s1_addr),
    .wr_data(s1_y),
    .rd_en  (proc),
    .rd_addr(beat_addr),
    .rd_data(bg_y)
  );

  assign diff   = (s1_y >= bg_y) ? s1_y - bg_y : bg_y - s1_y;
  assign object = s1_valid && !frame_train && bg_loaded && (diff > PIX_W'(DIFF_TH));

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_ACTIVE: begin
        if (frame_end)  state_next = ST_FLUSH;
        else if (proc)  state_next = ST_ACTIVE;
      end
      ST_FLUSH:  if (!s1_valid) state_next = ST_REPORT;
      ST_REPORT: if (res_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    res_d         = '0;
    present       = !frame_train && bg_loaded && (count >= NW'(MIN_PIX));
    res_d.present = present;
    res_d.train   = frame_train;
    res_d.err     = err || (!frame_train && !bg_loaded);
    res_d.count   = BB_W'(count);
    if (present) begin
      res_d.top    = BB_W'(top);
      res_d.bottom = BB_W'(bottom);
      res_d.left   = BB_W'(bb_left);
      res_d.right  = BB_W'(bb_right);
      res_d.width  = BB_W'(bb_right) - BB_W'(bb_left) + BB_W'(1);
      res_d.height = BB_W'(bottom) - BB_W'(top) + BB_W'(1);
    end
  end

  // S1 payload needs no reset: s1_valid qualifies it.
  always_ff @(posedge clk) begin
    if (proc) begin
      s1_y    <= y;
      s1_addr <= beat_addr;
      s1_col  <= beat_col;
      s1_row  <= beat_row;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      frame_train <= 1'b0;
      err         <= 1'b0;
      bg_loaded   <= 1'b0;
      col         <= '0;
      row         <= '0;
      count       <= '0;
      top         <= '0;
      bottom      <= '0;
      bb_left     <= '0;
      bb_right    <= '0;
      res_q       <= '0;
    end else begin
      s1_valid <= proc;
      if (proc) begin
        col <= eol_eff ? '0 : beat_col + CW'(1);
        row <= eol_eff ? beat_row + RW'(1) : beat_row;
      end
      // An SOF inside a frame aborts it; the restarted frame inherits the error.
      if (start) begin
        frame_train <= train;
        err         <= (state == ST_ACTIVE) || beat_err;
      end else if (proc) begin
        err <= err || beat_err;
      end
      // Clearing on SOF wins over a stale S2 update from the aborted frame.
      if (start) begin
        count <= '0;
      end else if (object) begin
        count <= count + NW'(1);
        if (count == '0) begin
          top      <= s1_row;
          bottom   <= s1_row;
          bb_left  <= s1_col;
          bb_right <= s1_col;
        end else begin
          if (s1_row < top)      top      <= s1_row;
          if (s1_row > bottom)   bottom   <= s1_row;
          if (s1_col < bb_left)  bb_left  <= s1_col;
          if (s1_col > bb_right) bb_right <= s1_col;
        end
      end
      if (state == ST_FLUSH && !s1_valid) begin
        res_q <= res_d;
        if (frame_train && !err) bg_loaded <= 1'b1;
      end
    end
  end

  assign res_present = res_q.present;
  assign res_train   = res_q.train;
  assign res_err     = res_q.err;
  assign res_top     = res_q.top[RW-1:0];
  assign res_bottom  = res_q.bottom[RW-1:0];
  assign res_left    = res_q.left[CW-1:0];
  assign res_right   = res_q.right[CW-1:0];
  assign res_width   = res_q.width[CW:0];
  assign res_height  = res_q.height[RW:0];
  assign res_count   = res_q.count[NW-1:0];

  // The shared record is wider than this frame geometry needs; the spare bits are intentionally dropped.
  logic res_unused;
  assign res_unused = &{1'b0, res_q};

endmodule

// File: tb/tb_sign_frame_frontend.sv
// Directed bench for sign_frame_frontend on an 8x4 frame with hand-computed results.
module tb_sign_frame_frontend;

  localparam int PIX_W = 8;
  localparam int FW    = 8;
  localparam int FH    = 4;
  localparam int CW    = 3;
  localparam int RW    = 2;
  localparam int NW    = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic             train;
  logic             pix_valid, pix_ready, pix_sof, pix_eol;
  logic [PIX_W-1:0] red, green, blue;
  logic             res_valid, res_ready;
  logic             res_present, res_train, res_err;
  logic [RW-1:0]    res_top, res_bottom;
  logic [CW-1:0]    res_left, res_right;
  logic [CW:0]      res_width;
  logic [RW:0]      res_height;
  logic [NW-1:0]    res_count;

  int checks = 0;
  int errors = 0;

  sign_frame_frontend #(
    .PIX_W  (PIX_W),
    .FRAME_W(FW),
    .FRAME_H(FH),
    .DIFF_TH(24),
    .MIN_PIX(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .train      (train),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_sof    (pix_sof),
    .pix_eol    (pix_eol),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_present(res_present),
    .res_train  (res_train),
    .res_err    (res_err),
    .res_top    (res_top),
    .res_bottom (res_bottom),
    .res_left   (res_left),
    .res_right  (res_right),
    .res_width  (res_width),
    .res_height (res_height),
    .res_count  (res_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pix(input logic sof, input logic eol, input logic [PIX_W-1:0] v);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_eol   = eol;
    red       = v;
    green     = v;
    blue      = v;
    tick();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
    pix_eol   = 1'b0;
  endtask

  // Grey frame: 200 inside rows r0..r1 / cols c0..c1, 16 elsewhere; row 0 may end early at short_col.
  task automatic send_frame(input logic trn, input int r0, input int r1, input int c0, input int c1,
                            input int short_col, input int max_beats);
    int n = 0;
    train = trn;
    for (int r = 0; r < FH; r++) begin
      int row_len = (r == 0 && short_col >= 0) ? short_col + 1 : FW;
      for (int c = 0; c < row_len; c++) begin
        logic [PIX_W-1:0] v;
        if (n >= max_beats) return;
        v = (r >= r0 && r <= r1 && c >= c0 && c <= c1) ? 8'd200 : 8'd16;
        send_pix(r == 0 && c == 0, c == row_len - 1, v);
        n++;
      end
    end
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, ".valid"}, 32'(res_valid), 1);
  endtask

  task automatic expect_result(input string tag, input int present, input int trn, input int er,
                               input int top, input int bottom, input int left, input int right,
                               input int width, input int height, input int count);
    wait_valid(tag);
    check({tag, ".present"}, 32'(res_present), present);
    check({tag, ".train"},   32'(res_train),   trn);
    check({tag, ".err"},     32'(res_err),     er);
    check({tag, ".top"},     32'(res_top),     top);
    check({tag, ".bottom"},  32'(res_bottom),  bottom);
    check({tag, ".left"},    32'(res_left),    left);
    check({tag, ".right"},   32'(res_right),   right);
    check({tag, ".width"},   32'(res_width),   width);
    check({tag, ".height"},  32'(res_height),  height);
    check({tag, ".count"},   32'(res_count),   count);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check({tag, ".released"}, 32'(res_valid), 0);
  endtask

  initial begin
    rst = 1'b1;  train = 1'b0;  res_ready = 1'b0;
    pix_valid = 1'b0;  pix_sof = 1'b0;  pix_eol = 1'b0;
    red = '0;  green = '0;  blue = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst.pix_ready", 32'(pix_ready), 0);
    check("rst.res_valid", 32'(res_valid), 0);
    rst = 1'b0;
    tick();
    check("post_rst.pix_ready", 32'(pix_ready), 1);
    check("post_rst.res_valid", 32'(res_valid), 0);
    check("post_rst.count",     32'(res_count), 0);
    check("post_rst.err",       32'(res_err),   0);
    check("post_rst.width",     32'(res_width), 0);

    // No background yet
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    expect_result("nobg", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    // Learn a flat luma-16 background
    send_frame(1'b1, -1, -2, 0, 0, -1, 1000);
    expect_result("train", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);

    // Stray beats without SOF in IDLE are dropped
    repeat (3) send_pix(1'b0, 1'b0, 8'd200);
    check("stray.pix_ready", 32'(pix_ready), 1);

    // Object rows 1-2, cols 3-5, with result latency
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    check("lat.cycle1", 32'(res_valid), 0);
    tick();
    check("lat.cycle2", 32'(res_valid), 0);
    tick();
    check("lat.cycle3", 32'(res_valid), 1);
    expect_result("rect", 1, 0, 0, 1, 2, 3, 5, 3, 2, 6);

    // Below MIN_PIX
    send_frame(1'b0, 2, 2, 4, 4, -1, 1000);
    expect_result("single", 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Early EOL on row 0
    send_frame(1'b0, 1, 2, 3, 5, 5, 1000);
    expect_result("early_eol", 1, 0, 1, 1, 2, 3, 5, 3, 2, 6);

    // SOF mid-frame: aborted frame ends with an object pixel still in flight
    send_frame(1'b0, 1, 2, 3, 5, -1, 13);
    check("abort.no_result", 32'(res_valid), 0);
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    expect_result("restart", 1, 0, 1, 1, 2, 3, 5, 3, 2, 6);

    // Full top row object, error cleared again
    send_frame(1'b0, 0, 0, 0, 7, -1, 1000);
    expect_result("row0", 1, 0, 0, 0, 0, 0, 7, 8, 1, 8);

    // Result back-pressure
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    wait_valid("hold");
    for (int i = 0; i < 10; i++) begin
      check("hold.pix_ready", 32'(pix_ready), 0);
      check("hold.res_valid", 32'(res_valid), 1);
      check("hold.count",     32'(res_count), 6);
      check("hold.left",      32'(res_left),  3);
      tick();
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("hold.released",  32'(res_valid), 0);
    check("hold.pix_ready2", 32'(pix_ready), 1);

    // Reset while in REPORT discards the result and the background
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    wait_valid("rst_report");
    rst = 1'b1;
    tick();
    check("rst_report.res_valid", 32'(res_valid), 0);
    check("rst_report.pix_ready", 32'(pix_ready), 0);
    rst = 1'b0;
    tick();
    check("rst_report.res_valid2", 32'(res_valid), 0);
    send_frame(1'b0, 1, 2, 3, 5, -1, 1000);
    expect_result("post_rst_frame", 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
